// File: rtl/seg7_pkg.sv
// Shared types and active-low segment codes for the 7-segment scan driver.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_ZERO  = 7'b1000000;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam seg_t SEG_D0 = 7'b1000000;
  localparam seg_t SEG_D1 = 7'b1111001;
  localparam seg_t SEG_D2 = 7'b0100100;
  localparam seg_t SEG_D3 = 7'b0110000;
  localparam seg_t SEG_D4 = 7'b0011001;
  localparam seg_t SEG_D5 = 7'b0010010;
  localparam seg_t SEG_D6 = 7'b0000010;
  localparam seg_t SEG_D7 = 7'b1111000;
  localparam seg_t SEG_D8 = 7'b0000000;
  localparam seg_t SEG_D9 = 7'b0010000;

  typedef enum logic [1:0] {
    IDX_U = 2'd0,
    IDX_T = 2'd1,
    IDX_H = 2'd2
  } digit_idx_t;

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot/digit sequencer: exposes next-cycle digit index and dead-time flag so
// the top can register its outputs in step with the counters.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 100000,
  parameter int unsigned DEAD_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output digit_idx_t idx_nxt_c,
  output logic       dead_nxt_c,
  output logic       frame_wrap_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] slot_q, slot_d;
  digit_idx_t       idx_q, idx_d;
  logic             slot_end;

  always_comb begin
    slot_end = (slot_q == CNT_W'(CLK_DIV - 1));
    slot_d   = slot_q + CNT_W'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      slot_d = '0;
      case (idx_q)
        IDX_U:   idx_d = IDX_T;
        IDX_T:   idx_d = IDX_H;
        default: idx_d = IDX_U;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      idx_q  <= IDX_U;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  assign idx_nxt_c    = idx_d;
  assign dead_nxt_c   = (slot_d < CNT_W'(DEAD_CYC));
  assign frame_wrap_c = slot_end && (idx_q == IDX_H);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 3-digit common-anode driver with frame-synchronous double
// buffering, leading-zero blanking and per-slot dead time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 100000,
  parameter int unsigned DEAD_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] dig_u,
  input  logic [6:0] dig_t,
  input  logic [6:0] dig_h,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned NUM_DIG = 3;

  digit_idx_t idx_nxt_c;
  logic       dead_nxt_c;
  logic       frame_wrap_c;

  seg7_slot_timer #(
    .CLK_DIV  (CLK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_nxt_c    (idx_nxt_c),
    .dead_nxt_c   (dead_nxt_c),
    .frame_wrap_c (frame_wrap_c)
  );

  seg_t [NUM_DIG-1:0] shadow_q, shadow_d;
  seg_t [NUM_DIG-1:0] active_q, active_d;
  logic               pending_q, pending_d;
  seg_t               seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               frame_done_q;
  logic               h_blank, t_blank;

  // Commit happens before capture so a load on the boundary edge waits a frame
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_wrap_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = {dig_h, dig_t, dig_u};
      pending_d = 1'b1;
    end
  end

  // Output lookahead: drive what the next cycle's slot/idx/active call for
  always_comb begin
    h_blank = blank_lz && (active_d[2] == SEG_ZERO);
    t_blank = h_blank && (active_d[1] == SEG_ZERO);
    an_d    = 4'b1111;
    seg_d   = SEG_BLANK;
    if (!dead_nxt_c) begin
      case (idx_nxt_c)
        IDX_U: begin
          an_d  = 4'b1110;
          seg_d = active_d[0];
        end
        IDX_T: begin
          an_d  = 4'b1101;
          seg_d = t_blank ? SEG_BLANK : active_d[1];
        end
        IDX_H: begin
          an_d  = 4'b1011;
          seg_d = h_blank ? SEG_BLANK : active_d[2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= {NUM_DIG{SEG_BLANK}};
      active_q     <= {NUM_DIG{SEG_BLANK}};
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_wrap_c;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
